// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared branch-predictor types and 2-bit counter helpers.
// Revision    : 1.0
// ============================================================================
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef logic [1:0] ctr_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t r;
        r = c;
        if (taken && c != CTR_ST)
            r = c + 2'd1;
        else if (!taken && c != CTR_SNT)
            r = c - 2'd1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter32.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter32
// Description : 32-bit event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0
// ============================================================================
module sat_counter32 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_inc,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (!rstn)
            r_count <= 32'd0;
        else if (i_inc && r_count != 32'hFFFF_FFFF)
            r_count <= r_count + 32'd1;
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Gshare direction predictor with 1-cycle lookup and
//               non-speculative global history.
// Revision    : 1.0
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W  = 8,
    parameter int PC_LSB = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      lookup_pc,
    output logic [IDX_W-1:0] pc_xor_global_history,
    output logic             prediction,
    input  logic             update_valid,
    input  logic [IDX_W-1:0] update_index,
    input  logic             update_taken,
    input  logic             update_miss,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_misses
);

    localparam int C_DEPTH = 2 ** IDX_W;

    logic [IDX_W-1:0] r_ghr;
    ctr_t             r_table [C_DEPTH];
    logic             r_prediction;

    logic [IDX_W-1:0] w_idx;
    ctr_t             w_upd_ctr;
    logic             w_bypass;
    logic             w_unused_pc;

    // Only a slice of the PC feeds the hash; the rest is deliberately ignored.
    assign w_unused_pc = ^lookup_pc;

    assign w_idx     = lookup_pc[PC_LSB+IDX_W-1:PC_LSB] ^ r_ghr;
    assign w_upd_ctr = ctr_next(r_table[update_index], update_taken);
    assign w_bypass  = update_valid && (update_index == w_idx);

    // Flop array rather than RAM so every counter can return to weakly
    // not-taken in one reset cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < C_DEPTH; i++)
                r_table[i] <= CTR_WNT;
            r_ghr        <= '0;
            r_prediction <= 1'b0;
        end else begin
            if (update_valid) begin
                r_table[update_index] <= w_upd_ctr;
                r_ghr                 <= {r_ghr[IDX_W-2:0], update_taken};
            end
            r_prediction <= w_bypass ? w_upd_ctr[1] : r_table[w_idx][1];
        end
    end

    assign pc_xor_global_history = w_idx;
    assign prediction            = r_prediction;

    sat_counter32 u_stat_branches (
        .clk     (clk),
        .rstn    (rstn),
        .i_inc   (update_valid),
        .o_count (stat_branches)
    );

    sat_counter32 u_stat_misses (
        .clk     (clk),
        .rstn    (rstn),
        .i_inc   (update_valid && update_miss),
        .o_count (stat_misses)
    );

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Scoreboard bench for branch_predictor with directed vectors.
// Revision    : 1.0
// ============================================================================
module tb_branch_predictor;

    logic        clk;
    logic        rstn;
    logic [31:0] lookup_pc;
    logic [7:0]  pc_xor_global_history;
    logic        prediction;
    logic        update_valid;
    logic [7:0]  update_index;
    logic        update_taken;
    logic        update_miss;
    logic [31:0] stat_branches;
    logic [31:0] stat_misses;

    branch_predictor #(.IDX_W(8), .PC_LSB(2)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .lookup_pc             (lookup_pc),
        .pc_xor_global_history (pc_xor_global_history),
        .prediction            (prediction),
        .update_valid          (update_valid),
        .update_index          (update_index),
        .update_taken          (update_taken),
        .update_miss           (update_miss),
        .stat_branches         (stat_branches),
        .stat_misses           (stat_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_PRED = 0;
    localparam int K_HASH = 1;
    localparam int K_BR   = 2;
    localparam int K_MISS = 3;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_at(input int d, input int k, input logic [31:0] v, input string n);
        exp_t e;
        e.due  = d;
        e.kind = k;
        e.val  = v;
        e.name = n;
        q.push_back(e);
    endtask

    // Monitor: compares every expectation that has come due this cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                logic [31:0] act;
                case (q[i].kind)
                    K_PRED:  act = {31'd0, prediction};
                    K_HASH:  act = {24'd0, pc_xor_global_history};
                    K_BR:    act = stat_branches;
                    default: act = stat_misses;
                endcase
                n_tests++;
                if (act !== q[i].val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %0h expected %0h", q[i].name, cyc, act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pc_for(input logic [7:0] idx, input logic [7:0] ghr);
        return {22'd0, idx ^ ghr, 2'b00};
    endfunction

    task automatic look(input logic [31:0] pc, input logic [7:0] h, input logic p, input string n);
        lookup_pc = pc;
        expect_at(cyc, K_HASH, {24'd0, h}, {n, "_hash"});
        expect_at(cyc + 1, K_PRED, {31'd0, p}, {n, "_pred"});
        step();
    endtask

    task automatic upd(input logic [7:0] idx, input logic t, input logic m);
        update_valid = 1'b1;
        update_index = idx;
        update_taken = t;
        update_miss  = m;
        step();
        update_valid = 1'b0;
        update_miss  = 1'b0;
    endtask

    task automatic chk_stats(input logic [31:0] b, input logic [31:0] m, input string n);
        expect_at(cyc, K_BR, b, {n, "_branches"});
        expect_at(cyc, K_MISS, m, {n, "_misses"});
    endtask

    initial begin
        // Reset with an update pending that must be ignored.
        rstn         = 1'b0;
        lookup_pc    = 32'd0;
        update_valid = 1'b1;
        update_index = 8'h00;
        update_taken = 1'b1;
        update_miss  = 1'b1;
        step();
        step();
        update_valid = 1'b0;
        update_miss  = 1'b0;
        rstn         = 1'b1;
        expect_at(cyc, K_PRED, 32'd0, "reset_pred");
        chk_stats(32'd0, 32'd0, "reset");

        for (int i = 0; i < 256; i++)
            look(32'(i) * 32'd4, 8'(i), 1'b0, "sweep");

        // Training: ghr 00 -> 01 -> 03, ctr[15] 1 -> 3 after three taken, 2 after not-taken.
        upd(8'h15, 1'b1, 1'b0);
        upd(8'h15, 1'b1, 1'b0);
        look(32'h58, 8'h15, 1'b1, "train2");
        look(32'h54, 8'h16, 1'b0, "train_other");
        upd(8'h15, 1'b1, 1'b0);
        upd(8'h15, 1'b0, 1'b0);
        look(pc_for(8'h15, 8'h0E), 8'h15, 1'b1, "train_ctr2");

        // Saturation: 3 then five not-taken -> 0; extra decrement must stay 0.
        upd(8'h15, 1'b1, 1'b0);
        repeat (5) upd(8'h15, 1'b0, 1'b0);
        look(pc_for(8'h15, 8'hA0), 8'h15, 1'b0, "sat_low");
        upd(8'h15, 1'b0, 1'b0);
        upd(8'h15, 1'b1, 1'b0);
        look(pc_for(8'h15, 8'h81), 8'h15, 1'b0, "sat_hold0");
        upd(8'h15, 1'b1, 1'b0);
        look(pc_for(8'h15, 8'h03), 8'h15, 1'b1, "sat_recover");

        // Bypass: same-cycle update to the looked-up entry.
        update_valid = 1'b1; update_index = 8'h20; update_taken = 1'b1;
        look(pc_for(8'h20, 8'h03), 8'h20, 1'b1, "bypass_t");
        update_valid = 1'b0;
        look(pc_for(8'h20, 8'h07), 8'h20, 1'b1, "bypass_table");
        update_valid = 1'b1; update_index = 8'h20; update_taken = 1'b0;
        look(pc_for(8'h20, 8'h07), 8'h20, 1'b0, "bypass_nt");
        update_valid = 1'b1; update_index = 8'h21; update_taken = 1'b1;
        look(pc_for(8'h20, 8'h0E), 8'h20, 1'b0, "bypass_other");
        update_valid = 1'b0;

        // Mid-operation reset with an in-flight update.
        update_valid = 1'b1; update_index = 8'h15; update_taken = 1'b1; update_miss = 1'b1;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        update_valid = 1'b0; update_miss = 1'b0;
        expect_at(cyc, K_PRED, 32'd0, "midrst_pred");
        chk_stats(32'd0, 32'd0, "midrst");
        look(32'h54, 8'h15, 1'b0, "midrst_ctr15");
        look(32'h84, 8'h21, 1'b0, "midrst_ctr21");

        // History: taken, not-taken, taken -> ghr 0x05.
        upd(8'h00, 1'b1, 1'b0);
        upd(8'h00, 1'b0, 1'b0);
        upd(8'h00, 1'b1, 1'b0);
        look(32'h0, 8'h05, 1'b0, "history");

        // Statistics: 10 branches in total, 3 misses.
        for (int i = 0; i < 7; i++)
            upd(8'h40 + 8'(i), 1'(i % 2), (i < 3) ? 1'b1 : 1'b0);
        chk_stats(32'd10, 32'd3, "stats10");
        step();

        force dut.u_stat_misses.r_count = 32'hFFFF_FFFE;
        step();
        release dut.u_stat_misses.r_count;
        expect_at(cyc, K_MISS, 32'hFFFF_FFFE, "stat_preset");
        step();
        upd(8'h50, 1'b1, 1'b1);
        chk_stats(32'd11, 32'hFFFF_FFFF, "stat_top");
        step();
        upd(8'h50, 1'b1, 1'b1);
        chk_stats(32'd12, 32'hFFFF_FFFF, "stat_sat");

        for (int i = 0; i < 5 && q.size() > 0; i++)
            step();
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
